// File: rtl/npu_fp_pkg.sv
// -----------------------------------------------------------------------------
// npu_fp_pkg
//   Shared floating-point definitions for the NPU output path.
//   - BF16_EXP_BIAS / BF16_EXP_MAX : bfloat16 exponent bias and the all-ones
//     exponent code used for infinity.
//   - EXP_WIDTH : width of the signed intermediate exponent. It is wide enough
//     for 158 - 31 + (-128) = -1 up to 158 + 127 = 285 without wrapping.
//   - bf16_t : packed bfloat16 word {sign, exp, mant}.
// -----------------------------------------------------------------------------
package npu_fp_pkg;

    localparam int BF16_EXP_BIAS = 127;
    localparam int BF16_EXP_MAX  = 255;
    localparam int EXP_WIDTH     = 10;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

endpackage

// File: rtl/acc_to_bf16_if.sv
// -----------------------------------------------------------------------------
// acc_to_bf16_if
//   Bundles the upstream (accumulator drain) and downstream (writeback buffer)
//   valid/ready channels of the accumulator-to-bf16 converter.
//   Upstream  : i_valid, o_ready, i_acc[ACC_WIDTH], i_scale_exp[SCALE_WIDTH]
//   Downstream: o_valid, i_ready, o_bf16[16], o_sat
//   Modports:
//     slave  - the converter (consumes i_*, produces o_*)
//     master - the environment around it (produces i_*, consumes o_*)
// -----------------------------------------------------------------------------
interface acc_to_bf16_if #(
    parameter int ACC_WIDTH   = 32,
    parameter int SCALE_WIDTH = 8
) ();

    logic                   i_valid;
    logic                   o_ready;
    logic [ACC_WIDTH-1:0]   i_acc;
    logic [SCALE_WIDTH-1:0] i_scale_exp;

    logic                   o_valid;
    logic                   i_ready;
    logic [15:0]            o_bf16;
    logic                   o_sat;

    modport slave (
        input  i_valid, i_acc, i_scale_exp, i_ready,
        output o_ready, o_valid, o_bf16, o_sat
    );

    modport master (
        output i_valid, i_acc, i_scale_exp, i_ready,
        input  o_ready, o_valid, o_bf16, o_sat
    );

endinterface

// File: rtl/find_leading_one.sv
// -----------------------------------------------------------------------------
// find_leading_one
//   Purely combinational leading-zero counter.
//   i_data   [WIDTH]     : word to scan
//   o_result [BIT_WIDTH] : number of zeros above the most significant set bit
//                          (0..WIDTH-1); 0 when i_data is zero, which callers
//                          must qualify separately.
// -----------------------------------------------------------------------------
module find_leading_one #(
    parameter int WIDTH     = 32,
    parameter int BIT_WIDTH = 5
) (
    input  logic [WIDTH-1:0]     i_data,
    output logic [BIT_WIDTH-1:0] o_result
);

    // Scan from LSB upward so the highest set bit is the last one to write
    // the result, giving MSB priority without a nested priority chain.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves it unassigned would otherwise infer a latch.
        o_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_result = BIT_WIDTH'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/acc_to_bf16.sv
// -----------------------------------------------------------------------------
// acc_to_bf16
//   Three-stage valid/ready pipeline converting a signed accumulator to
//   bfloat16, scaled by 2^i_scale_exp, with round-to-nearest-even,
//   saturation to +/-inf and flush-to-signed-zero (no subnormals).
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus (slave)   : i_valid/o_ready/i_acc/i_scale_exp upstream,
//                   o_valid/i_ready/o_bf16/o_sat downstream
//   S1 captures sign/magnitude, S2 normalises, S3 rounds and packs into the
//   output register. Each stage refills as soon as it empties or drains, so
//   bubbles collapse even while the output is stalled.
// -----------------------------------------------------------------------------
module acc_to_bf16
    import npu_fp_pkg::*;
#(
    parameter int ACC_WIDTH   = 32,
    parameter int SCALE_WIDTH = 8
) (
    input logic          i_clk,
    input logic          i_rstn,
    acc_to_bf16_if.slave bus
);

    localparam int LZC_WIDTH = $clog2(ACC_WIDTH);
    // Exponent of a value whose leading one sits at bit ACC_WIDTH-1.
    localparam int E_BASE    = BF16_EXP_BIAS + ACC_WIDTH - 1;

    localparam logic signed [EXP_WIDTH-1:0] E_SAT  = EXP_WIDTH'(BF16_EXP_MAX);
    localparam logic signed [EXP_WIDTH-1:0] E_ZERO = '0;

    // ---------------------------------------------------------------- control
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic load1, load2, load3, unload3;

    assign unload3     = v3_q & bus.i_ready;
    assign load3       = v2_q & (~v3_q | unload3);
    assign load2       = v1_q & (~v2_q | load3);
    // Combinational through i_ready: a full pipe can still accept when the
    // downstream drains this cycle.
    assign bus.o_ready = ~v1_q | load2;
    assign load1       = bus.i_valid & bus.o_ready;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (load1)        v1_d = 1'b1;
        else if (load2)   v1_d = 1'b0;
        if (load2)        v2_d = 1'b1;
        else if (load3)   v2_d = 1'b0;
        if (load3)        v3_d = 1'b1;
        else if (unload3) v3_d = 1'b0;
    end

    // ---------------------------------------------------------------- S1
    logic                   sign1_q;
    logic                   zero1_q;
    logic [ACC_WIDTH-1:0]   mag1_q;
    logic [SCALE_WIDTH-1:0] scale1_q;

    // NOTE: pure datapath registers carry no reset; they are only ever read
    // when their stage valid is set, and the valids are reset.
    always_ff @(posedge i_clk) begin
        if (load1) begin
            sign1_q  <= bus.i_acc[ACC_WIDTH-1];
            // Unsigned negate: the most negative input maps to 0x8000_0000.
            mag1_q   <= bus.i_acc[ACC_WIDTH-1] ? -bus.i_acc : bus.i_acc;
            zero1_q  <= (bus.i_acc == '0);
            scale1_q <= bus.i_scale_exp;
        end
    end

    // ---------------------------------------------------------------- S2
    logic [LZC_WIDTH-1:0]        lzc;
    logic signed [EXP_WIDTH-1:0] e_pre_d;

    find_leading_one #(
        .WIDTH    (ACC_WIDTH),
        .BIT_WIDTH(LZC_WIDTH)
    ) u_find_leading_one (
        .i_data  (mag1_q),
        .o_result(lzc)
    );

    // Sign-extending the scale via a size cast of its signed view.
    assign e_pre_d = EXP_WIDTH'(E_BASE) - EXP_WIDTH'(lzc)
                   + EXP_WIDTH'(signed'(scale1_q));

    logic                        sign2_q;
    logic                        zero2_q;
    logic [ACC_WIDTH-2:0]        norm2_q;   // normalised magnitude, hidden bit dropped
    logic signed [EXP_WIDTH-1:0] e2_q;

    always_ff @(posedge i_clk) begin
        if (load2) begin
            sign2_q <= sign1_q;
            zero2_q <= zero1_q;
            norm2_q <= (ACC_WIDTH-1)'(mag1_q << lzc);
            e2_q    <= e_pre_d;
        end
    end

    // ---------------------------------------------------------------- S3
    logic [6:0]                  mant;
    logic                        guard;
    logic                        sticky;
    logic                        round_up;
    logic [7:0]                  mant_rnd;
    logic signed [EXP_WIDTH-1:0] e_fin;
    bf16_t                       res_d;
    logic                        sat_d;

    always_comb begin
        mant     = norm2_q[ACC_WIDTH-2 -: 7];
        guard    = norm2_q[ACC_WIDTH-9];
        sticky   = |norm2_q[ACC_WIDTH-10:0];
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {7'b0, round_up};
        // A carry out of the 7-bit mantissa leaves mant_rnd[6:0] == 0 and
        // bumps the exponent by one.
        e_fin    = e2_q + EXP_WIDTH'(mant_rnd[7]);

        res_d    = '0;
        sat_d    = 1'b0;
        if (zero2_q) begin
            res_d = '0;
        end else if (e_fin >= E_SAT) begin
            res_d.sign = sign2_q;
            res_d.exp  = '1;
            sat_d      = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            res_d.sign = sign2_q;
        end else begin
            res_d.sign = sign2_q;
            res_d.exp  = e_fin[7:0];
            res_d.mant = mant_rnd[6:0];
        end
    end

    bf16_t bf16_q;
    logic  sat_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            bf16_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            if (load3) begin
                bf16_q <= res_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign bus.o_valid = v3_q;
    assign bus.o_bf16  = bf16_q;
    assign bus.o_sat   = sat_q;

endmodule
